fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined processor.
- Owns the PC and issues word fetches to instruction memory over a request/grant/response interface.
- Buffers returned instructions in a small FIFO and presents them to the decode stage with a valid/stall handshake.
- Discards stale fetches after a redirect, and stops fetching permanently once decode reports a halt.

---
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/grant/response plus the decode handshake.
// master = fetch stage side, slave = memory/decode environment side.
interface fetch_stage_if;
  // Instruction memory
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  // Decode
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  // Status
  logic        halted;
  logic        err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr, pc_plus2, instr_valid,
    input  stall, redirect, redirect_pc, halt,
    output halted, err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr, pc_plus2, instr_valid,
    output stall, redirect, redirect_pc, halt,
    input  halted, err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited fetches, buffers responses
// in a small FIFO for decode, discards stale responses after redirect/halt.
module fetch_stage #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned SW = CW + 1;
  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } entry_t;

  // Control state
  state_t        r_state;
  logic [15:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic          r_err;

  // Fetch buffer
  entry_t        r_fifo [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Fetch addresses of in-flight requests, oldest first
  logic [15:0]   r_addrq [BUF_DEPTH];
  logic [PW-1:0] r_aq_rd;
  logic [PW-1:0] r_aq_wr;

  logic          w_run;
  logic          w_credit;
  logic          w_req;
  logic          w_issue;
  logic          w_resp;
  logic          w_spurious;
  logic          w_valid;
  logic          w_halt;
  logic          w_redir;
  logic          w_flush;
  logic          w_accept;
  logic          w_drop_resp;
  logic          w_push;
  logic [CW-1:0] w_inflight_nxt;
  logic [15:0]   w_redirect_pc;
  entry_t        w_push_entry;
  entry_t        w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode and priority: halt beats redirect beats accept
  always_comb begin
    w_run          = (r_state == ST_RUN);
    w_credit       = ({1'b0, r_count} + {1'b0, r_inflight}) < SW'(BUF_DEPTH);
    w_req          = w_run & ~rst & ~bus.redirect & w_credit;
    w_issue        = w_req & bus.imem_gnt;
    w_resp         = bus.imem_rvalid & (r_inflight != '0);
    w_spurious     = bus.imem_rvalid & (r_inflight == '0);
    w_valid        = w_run & (r_count != '0);
    w_halt         = w_valid & bus.halt;
    w_redir        = w_run & bus.redirect & ~w_halt;
    w_flush        = w_halt | w_redir;
    w_accept       = w_valid & ~bus.stall & ~w_flush;
    w_drop_resp    = w_resp & (r_drop != '0);
    w_push         = w_resp & ~w_drop_resp & ~w_flush & w_run;
    w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(w_resp);
    w_redirect_pc  = bus.redirect_pc & 16'hFFFE;
    w_push_entry   = '{instr: bus.imem_rdata, pc_plus2: r_addrq[r_aq_rd] + 16'd2};
    w_head         = r_fifo[r_rd_ptr];
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? w_head.instr : NOP;
  assign bus.pc_plus2    = w_valid ? w_head.pc_plus2 : 16'h0000;
  assign bus.halted      = (r_state == ST_HALTED);
  assign bus.err         = r_err;

  // RUN/HALTED state machine with PC, in-flight, drop and sticky error tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_spurious) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        ST_RUN: begin
          if (w_halt) begin
            r_state <= ST_HALTED;
            r_drop  <= w_inflight_nxt;
          end else if (w_redir) begin
            r_pc   <= w_redirect_pc;
            r_drop <= w_inflight_nxt;
          end else begin
            if (w_issue) begin
              r_pc <= r_pc + 16'd2;
            end
            if (w_drop_resp) begin
              r_drop <= r_drop - CW'(1);
            end
          end
        end
        ST_HALTED: begin
          if (w_drop_resp) begin
            r_drop <= r_drop - CW'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Fetch-buffer pointers and occupancy; a flush empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_accept) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_accept);
    end
  end

  // Address side-queue pointers; survives flushes so dropped responses stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aq_rd <= '0;
      r_aq_wr <= '0;
    end else begin
      if (w_issue) begin
        r_aq_wr <= ptr_inc(r_aq_wr);
      end
      if (w_resp) begin
        r_aq_rd <= ptr_inc(r_aq_rd);
      end
    end
  end

  // Storage arrays; contents are only meaningful behind the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
    if (w_issue) begin
      r_addrq[r_aq_wr] <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences and a random run
// against a queue-based program-order model with an in-order memory model.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  fetch_stage_if bus ();

  fetch_stage #(.BUF_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        stall;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc2;
  } vec_t;

  int          checks;
  int          errors;
  int          cyc;
  bit          rand_mode;
  int          fix_lat;
  bit          inject;

  mreq_t       mq[$];     // memory: issued, not yet answered
  logic [15:0] bufq[$];   // model: fetch addresses waiting for decode
  logic [15:0] acc_q[$];  // pc_plus2 of accepted instructions
  logic [15:0] iss_q[$];  // issued fetch addresses
  int          m_drop;
  logic        m_halted;
  logic        m_err;
  logic [15:0] m_pc;

  vec_t        tbl[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs, check outputs against the model, then advance the model.
  task automatic cyc_a(input logic st, input logic rd, input logic [15:0] rpc, input logic hl);
    logic        resp, spur, gnt, exp_req, exp_valid, halting, redir, accept;
    logic [15:0] raddr;
    int          lat;
    resp  = 1'b0;
    spur  = 1'b0;
    raddr = 16'h0000;
    if (inject) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 16'hBEEF;
      spur            = (mq.size() == 0);
    end else if (mq.size() > 0 && mq[0].due <= cyc && (!rand_mode || $urandom_range(0, 2) != 0)) begin
      raddr           = mq[0].addr;
      resp            = 1'b1;
      void'(mq.pop_front());
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = raddr ^ 16'hA5A5;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 16'($urandom);
    end
    gnt             = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.imem_gnt    = gnt;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt        = hl;
    #1;
    exp_req   = !m_halted && !rd && ((bufq.size() + mq.size() + (resp ? 1 : 0)) < DEPTH);
    exp_valid = !m_halted && (bufq.size() > 0);
    chk("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      chk("instr", bus.instr, bufq[0] ^ 16'hA5A5);
      chk("pc_plus2", bus.pc_plus2, bufq[0] + 16'd2);
    end else begin
      chk("nop_instr", bus.instr, 16'h0800);
      chk("nop_pc_plus2", bus.pc_plus2, 16'h0000);
    end
    chk("halted", bus.halted, m_halted);
    chk("err", bus.err, m_err);

    if (bus.imem_req && gnt) begin
      lat = rand_mode ? $urandom_range(1, 3) : fix_lat;
      mq.push_back('{bus.imem_addr, cyc + lat});
      iss_q.push_back(bus.imem_addr);
    end
    if (exp_req && gnt) m_pc = m_pc + 16'd2;
    halting = !m_halted && hl && exp_valid;
    redir   = !m_halted && rd && !halting;
    accept  = exp_valid && !st && !halting && !redir;
    if (accept) begin
      acc_q.push_back(bufq[0] + 16'd2);
      void'(bufq.pop_front());
    end
    if (resp) begin
      if (m_drop > 0) m_drop--;
      else if (!halting && !redir && !m_halted) bufq.push_back(raddr);
    end
    if (halting || redir) begin
      bufq.delete();
      m_drop = mq.size();
    end
    if (redir) m_pc = rpc & 16'hFFFE;
    if (halting) m_halted = 1'b1;
    if (spur) m_err = 1'b1;
  endtask

  task automatic cyc_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic hl);
    cyc_a(st, rd, rpc, hl);
    cyc_b();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 16'h0800);
    chk("rst_pc_plus2", bus.pc_plus2, 16'h0000);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_err", bus.err, 1'b0);
  endtask

  // Assert reset (asynchronously), check reset values, release away from the clock edge.
  task automatic do_reset();
    rst             = 1'b1;
    inject          = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt        = 1'b0;
    #1;
    chk_reset_outputs();
    mq.delete();
    bufq.delete();
    acc_q.delete();
    iss_q.delete();
    m_drop   = 0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_pc     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    bit   found;
    logic st, rd;
    logic [15:0] rpc;

    // stall, req, addr, valid, instr, pc_plus2 -- 1-cycle memory returning addr ^ A5A5
    tbl[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0800, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'hA5A5, 16'h0002};
    tbl[3]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'hA5A7, 16'h0004};
    tbl[4]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'hA5A1, 16'h0006};
    tbl[5]  = '{1'b1, 1'b1, 16'h000A, 1'b1, 16'hA5A1, 16'h0006};
    tbl[6]  = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'hA5A1, 16'h0006};
    tbl[7]  = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'hA5A1, 16'h0006};
    tbl[8]  = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'hA5A1, 16'h0006};
    tbl[9]  = '{1'b1, 1'b0, 16'h000C, 1'b1, 16'hA5A1, 16'h0006};
    tbl[10] = '{1'b0, 1'b0, 16'h000C, 1'b1, 16'hA5A1, 16'h0006};
    tbl[11] = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'hA5A3, 16'h0008};
    tbl[12] = '{1'b0, 1'b1, 16'h000E, 1'b1, 16'hA5AD, 16'h000A};
    tbl[13] = '{1'b0, 1'b1, 16'h0010, 1'b1, 16'hA5AF, 16'h000C};
    tbl[14] = '{1'b0, 1'b1, 16'h0012, 1'b1, 16'hA5A9, 16'h000E};
    tbl[15] = '{1'b0, 1'b1, 16'h0014, 1'b1, 16'hA5AB, 16'h0010};

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rand_mode = 1'b0;
    fix_lat   = 1;
    inject    = 1'b0;

    // Streaming fetch, then a 6-cycle stall that fills the buffer
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc_a(tbl[i].stall, 1'b0, 16'h0000, 1'b0);
      chk($sformatf("tbl%0d_req", i), bus.imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), bus.instr_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_pc_plus2", i), bus.pc_plus2, tbl[i].e_pc2);
      cyc_b();
    end

    // Redirect with two fetches in flight (2-cycle memory)
    do_reset();
    fix_lat = 2;
    n = 0;
    while (mq.size() != 2 && n < 20) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      n++;
    end
    chk("redir_setup_inflight", 16'(mq.size()), 16'd2);
    cyc_a(1'b0, 1'b1, 16'h0101, 1'b0);
    chk("redir_no_req", bus.imem_req, 1'b0);
    cyc_b();
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("redir_valid_next", bus.instr_valid, 1'b0);
    chk("redir_req_next", bus.imem_req, 1'b1);
    chk("redir_addr_next", bus.imem_addr, 16'h0100);
    cyc_b();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
      if (bus.instr_valid) begin
        chk("redir_first_pc_plus2", bus.pc_plus2, 16'h0102);
        chk("redir_first_instr", bus.instr, 16'hA4A5);
        found = 1'b1;
      end
      cyc_b();
    end
    chk("redir_found", found, 1'b1);

    // PC wrap from FFFC
    do_reset();
    fix_lat = 1;
    step(1'b0, 1'b1, 16'hFFFC, 1'b0);
    iss_q.delete();
    acc_q.delete();
    repeat (10) step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_enough", (iss_q.size() >= 3 && acc_q.size() >= 3), 1'b1);
    if (iss_q.size() >= 3 && acc_q.size() >= 3) begin
      chk("wrap_iss0", iss_q[0], 16'hFFFC);
      chk("wrap_iss1", iss_q[1], 16'hFFFE);
      chk("wrap_iss2", iss_q[2], 16'h0000);
      chk("wrap_acc0", acc_q[0], 16'hFFFE);
      chk("wrap_acc1", acc_q[1], 16'h0000);
      chk("wrap_acc2", acc_q[2], 16'h0002);
    end

    // Halt with fetches in flight; redirects afterwards are ignored; reset restarts
    do_reset();
    fix_lat = 2;
    n = 0;
    while (!(bufq.size() > 0 && mq.size() > 0) && n < 40) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      n++;
    end
    chk("halt_setup", (bufq.size() > 0 && mq.size() > 0), 1'b1);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("halt_valid_at_h", bus.instr_valid, 1'b1);
    cyc_b();
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("halt_halted_next", bus.halted, 1'b1);
    chk("halt_valid_next", bus.instr_valid, 1'b0);
    chk("halt_req_next", bus.imem_req, 1'b0);
    cyc_b();
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b0, 1'b1, 16'($urandom), 1'b0);
      chk("halt_redirect_ignored_req", bus.imem_req, 1'b0);
      chk("halt_stays", bus.halted, 1'b1);
      cyc_b();
    end
    chk("halt_drain_no_err", bus.err, 1'b0);
    do_reset();
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("restart_req", bus.imem_req, 1'b1);
    chk("restart_addr", bus.imem_addr, 16'h0000);
    cyc_b();

    // Spurious response with nothing in flight
    do_reset();
    fix_lat = 1;
    repeat (10) step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("err_setup", (mq.size() == 0 && bufq.size() == DEPTH), 1'b1);
    chk("full_no_req", bus.imem_req, 1'b0);
    inject = 1'b1;
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    inject = 1'b0;
    cyc_a(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("err_set", bus.err, 1'b1);
    cyc_b();
    acc_q.delete();
    repeat (10) step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("err_sticky", bus.err, 1'b1);
    chk("err_fifo_kept", (acc_q.size() >= 4), 1'b1);
    if (acc_q.size() >= 4) begin
      chk("err_acc0", acc_q[0], 16'h0002);
      chk("err_acc1", acc_q[1], 16'h0004);
      chk("err_acc2", acc_q[2], 16'h0006);
      chk("err_acc3", acc_q[3], 16'h0008);
    end

    // Random grants, latencies, stalls and redirects against the model
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 39) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      step(st, rd, rpc, 1'b0);
    end
    chk("rand_progress", (acc_q.size() > 200), 1'b1);

    // Reset in the middle of traffic, then run cleanly
    do_reset();
    rand_mode = 1'b0;
    fix_lat   = 1;
    repeat (8) step(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
